// File: rtl/blockmem_1p_arb.sv
// blockmem_1p_arb: round-robin, burst-limited arbiter sharing one single-port block memory between two requesters.
module blockmem_1p_arb #(
  parameter int G_DATAWIDTH = 32,
  parameter int G_MEMDEPTH  = 1024,
  parameter int G_ADDRWIDTH = $clog2(G_MEMDEPTH),
  parameter int G_BWENABLE  = 0,
  parameter int G_WEWIDTH   = ((((G_DATAWIDTH+7)/8)-1)*G_BWENABLE)+1,
  parameter int G_RDLAT     = 1,
  parameter int G_MAXBURST  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   a_valid,
  output logic                   a_ready,
  input  logic [G_WEWIDTH-1:0]   a_we,
  input  logic [G_ADDRWIDTH-1:0] a_addr,
  input  logic [G_DATAWIDTH-1:0] a_wdata,
  output logic                   a_rvalid,
  output logic [G_DATAWIDTH-1:0] a_rdata,
  input  logic                   b_valid,
  output logic                   b_ready,
  input  logic [G_WEWIDTH-1:0]   b_we,
  input  logic [G_ADDRWIDTH-1:0] b_addr,
  input  logic [G_DATAWIDTH-1:0] b_wdata,
  output logic                   b_rvalid,
  output logic [G_DATAWIDTH-1:0] b_rdata,
  output logic                   mem_en,
  output logic [G_WEWIDTH-1:0]   mem_we,
  output logic [G_ADDRWIDTH-1:0] mem_addr,
  output logic [G_DATAWIDTH-1:0] mem_din,
  input  logic [G_DATAWIDTH-1:0] mem_dout
);
  localparam logic [3:0] MAXB = 4'(G_MAXBURST);
  logic ptr, ptr_nx, gnt_a, gnt_b, gnt, other, flip, is_rd;
  logic [3:0] cnt, cnt_nx, cnt_inc;
  logic [G_WEWIDTH-1:0] win_we;
  logic [G_RDLAT-1:0] tag_rd, tag_port;
  logic [G_DATAWIDTH-1:0] a_rdata_q, b_rdata_q;
  // cnt counts consecutive grants to the pointer owner; it saturates at the burst limit
  always_comb begin
    gnt_a   = !rst && a_valid && (!b_valid || !ptr);
    gnt_b   = !rst && b_valid && (!a_valid || ptr);
    gnt     = gnt_a || gnt_b;
    other   = gnt_b ? a_valid : b_valid;
    cnt_inc = (gnt_b != ptr) ? 4'd1 : (cnt >= MAXB ? cnt : cnt + 4'd1);
    flip    = gnt && other && (cnt_inc >= MAXB);
    ptr_nx  = !gnt ? ptr : (flip ? !gnt_b : gnt_b);
    cnt_nx  = (!gnt || flip) ? 4'd0 : cnt_inc;
    win_we  = gnt_b ? b_we : a_we;
    is_rd   = gnt && (win_we == '0);
  end
  assign a_ready  = gnt_a;
  assign b_ready  = gnt_b;
  assign mem_en   = gnt;
  assign mem_we   = gnt ? win_we : '0;
  assign mem_addr = gnt_b ? b_addr : a_addr;
  assign mem_din  = gnt_b ? b_wdata : a_wdata;
  // responses are presented in the same cycle the memory drives its read data
  assign a_rvalid = !rst && tag_rd[G_RDLAT-1] && !tag_port[G_RDLAT-1];
  assign b_rvalid = !rst && tag_rd[G_RDLAT-1] && tag_port[G_RDLAT-1];
  assign a_rdata  = a_rvalid ? mem_dout : a_rdata_q;
  assign b_rdata  = b_rvalid ? mem_dout : b_rdata_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= 1'b0;
      cnt       <= '0;
      tag_rd    <= '0;
      tag_port  <= '0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      ptr      <= ptr_nx;
      cnt      <= cnt_nx;
      tag_rd   <= (tag_rd << 1) | G_RDLAT'(is_rd);
      tag_port <= (tag_port << 1) | G_RDLAT'(gnt_b);
      if (a_rvalid) a_rdata_q <= mem_dout;
      if (b_rvalid) b_rdata_q <= mem_dout;
    end
  end
endmodule

// File: tb/tb_blockmem_1p_arb.sv
// tb_blockmem_1p_arb: drives two arbiters (read latency 1 and 2) with shared stimulus; a scoreboard checks read returns.
module tb_blockmem_1p_arb;
  localparam int DW = 32;
  localparam int AW = 10;
  typedef struct {logic port; logic [DW-1:0] data; int cyc;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a_valid = 1'b0, b_valid = 1'b0;
  logic a_we = 1'b0, b_we = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_wdata = '0, b_wdata = '0;
  logic a_ready [2], b_ready [2], a_rvalid [2], b_rvalid [2], mem_en [2], mem_we [2];
  logic [AW-1:0] mem_addr [2];
  logic [DW-1:0] a_rdata [2], b_rdata [2], mem_din [2], mem_dout [2];
  logic [DW-1:0] mem_arr [2][1024];
  logic [DW-1:0] p0, p1a, p1b;
  logic [DW-1:0] ref_mem [1024];
  exp_t sb [2][$];
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  blockmem_1p_arb #(.G_RDLAT(1)) d1 (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready[0]), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rvalid(a_rvalid[0]), .a_rdata(a_rdata[0]),
    .b_valid(b_valid), .b_ready(b_ready[0]), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rvalid(b_rvalid[0]), .b_rdata(b_rdata[0]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_din(mem_din[0]), .mem_dout(mem_dout[0])
  );
  blockmem_1p_arb #(.G_RDLAT(2)) d2 (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready[1]), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rvalid(a_rvalid[1]), .a_rdata(a_rdata[1]),
    .b_valid(b_valid), .b_ready(b_ready[1]), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rvalid(b_rvalid[1]), .b_rdata(b_rdata[1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_din(mem_din[1]), .mem_dout(mem_dout[1])
  );

  always @(posedge clk) begin
    if (mem_en[0] && mem_we[0]) mem_arr[0][mem_addr[0]] <= mem_din[0];
    if (mem_en[1] && mem_we[1]) mem_arr[1][mem_addr[1]] <= mem_din[1];
    p0  <= mem_arr[0][mem_addr[0]];
    p1a <= mem_arr[1][mem_addr[1]];
    p1b <= p1a;
  end
  assign mem_dout[0] = p0;
  assign mem_dout[1] = p1b;

  always @(negedge clk) begin
    exp_t e;
    logic [DW-1:0] got;
    if (rst) begin
      sb[0].delete();
      sb[1].delete();
    end
    for (int k = 0; k < 2; k++) begin
      if (a_rvalid[k] || b_rvalid[k]) begin
        checks++;
        if (sb[k].size() == 0) begin
          errors++;
          $display("FAIL rsp%0d_unexpected: rvalid a=%b b=%b, required no response", k, a_rvalid[k], b_rvalid[k]);
        end else begin
          e = sb[k].pop_front();
          got = b_rvalid[k] ? b_rdata[k] : a_rdata[k];
          if ({b_rvalid[k], a_rvalid[k]} !== (e.port ? 2'b10 : 2'b01) || got !== e.data || cyc != e.cyc) begin
            errors++;
            $display("FAIL rsp%0d: port b=%b data=%h cyc=%0d, required port b=%b data=%h cyc=%0d",
                     k, b_rvalid[k], got, cyc, e.port, e.data, e.cyc);
          end
        end
      end
      if (!rst && a_valid && a_ready[k] && !a_we) sb[k].push_back('{1'b0, ref_mem[a_addr], cyc + k + 1});
      if (!rst && b_valid && b_ready[k] && !b_we) sb[k].push_back('{1'b1, ref_mem[b_addr], cyc + k + 1});
    end
    if (!rst && a_valid && a_ready[0] && a_we) ref_mem[a_addr] = a_wdata;
    if (!rst && b_valid && b_ready[0] && b_we) ref_mem[b_addr] = b_wdata;
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    a_valid = 1'b1;
    step;
    step;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({a_ready[k], b_ready[k], mem_en[k], mem_we[k], a_rvalid[k], b_rvalid[k]} !== 6'b0 || a_rdata[k] !== '0 || b_rdata[k] !== '0) begin
        errors++;
        $display("FAIL reset%0d: rdy=%b%b en=%b we=%b rvalid=%b%b rdata=%h/%h, required all zero",
                 k, a_ready[k], b_ready[k], mem_en[k], mem_we[k], a_rvalid[k], b_rvalid[k], a_rdata[k], b_rdata[k]);
      end
    end
    step;
    rst = 1'b0;
    a_we = 1'b1;
    a_addr = 10'd5;
    a_wdata = 32'hDEADBEEF;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (a_ready[k] !== 1'b1 || b_ready[k] !== 1'b0 || mem_en[k] !== 1'b1 || mem_we[k] !== 1'b1 || mem_addr[k] !== 10'd5 || mem_din[k] !== 32'hDEADBEEF) begin
        errors++;
        $display("FAIL write_issue%0d: rdy=%b%b en=%b we=%b addr=%0d din=%h, required rdy=10 en=1 we=1 addr=5 din=deadbeef",
                 k, a_ready[k], b_ready[k], mem_en[k], mem_we[k], mem_addr[k], mem_din[k]);
      end
    end
  endtask

  task automatic test_read;
    step;
    a_we = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (a_ready[k] !== 1'b1 || mem_en[k] !== 1'b1 || mem_we[k] !== 1'b0 || mem_addr[k] !== 10'd5) begin
        errors++;
        $display("FAIL read_issue%0d: rdy=%b en=%b we=%b addr=%0d, required rdy=1 en=1 we=0 addr=5",
                 k, a_ready[k], mem_en[k], mem_we[k], mem_addr[k]);
      end
    end
    step;
    a_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (a_rvalid[0] !== 1'b1 || a_rdata[0] !== 32'hDEADBEEF || b_rvalid[0] !== 1'b0) begin
      errors++;
      $display("FAIL read_return: a_rvalid=%b a_rdata=%h b_rvalid=%b, required 1 deadbeef 0", a_rvalid[0], a_rdata[0], b_rvalid[0]);
    end
    step;
    @(negedge clk);
    checks++;
    if (a_rvalid[0] !== 1'b0 || a_rdata[0] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL read_pulse: a_rvalid=%b a_rdata=%h, required 0 deadbeef", a_rvalid[0], a_rdata[0]);
    end
  endtask

  task automatic test_round_robin;
    logic exp_a;
    step;
    a_valid = 1'b1; b_valid = 1'b1;
    a_we = 1'b1; b_we = 1'b1;
    a_addr = 10'd10; b_addr = 10'd20;
    for (int i = 0; i < 16; i++) begin
      exp_a = ((i / 4) % 2) == 0;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (a_ready[k] !== exp_a || b_ready[k] !== !exp_a || mem_en[k] !== 1'b1) begin
          errors++;
          $display("FAIL rr%0d_cycle%0d: rdy a=%b b=%b en=%b, required a=%b b=%b en=1",
                   k, i, a_ready[k], b_ready[k], mem_en[k], exp_a, !exp_a);
        end
      end
      step;
      a_wdata = 32'(i);
      b_wdata = 32'(i + 100);
    end
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

  task automatic test_burst_hold;
    logic [5:0] pat = 6'b100001;
    step;
    b_valid = 1'b1; b_addr = 10'd30;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (b_ready[k] !== 1'b1 || a_ready[k] !== 1'b0) begin
          errors++;
          $display("FAIL b_alone%0d_cycle%0d: rdy a=%b b=%b, required a=0 b=1", k, i, a_ready[k], b_ready[k]);
        end
      end
      step;
    end
    checks++;
    if (d1.ptr !== 1'b1) begin
      errors++;
      $display("FAIL b_alone_ptr: ptr=%b, required 1", d1.ptr);
    end
    a_valid = 1'b1; a_addr = 10'd31;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (b_ready[k] !== pat[i] || a_ready[k] !== !pat[i]) begin
          errors++;
          $display("FAIL join%0d_cycle%0d: rdy a=%b b=%b, required a=%b b=%b", k, i, a_ready[k], b_ready[k], !pat[i], pat[i]);
        end
      end
      if (i == 2) begin
        checks++;
        if (d1.ptr !== 1'b0 || d1.cnt !== 4'd1 || d2.ptr !== 1'b0 || d2.cnt !== 4'd1) begin
          errors++;
          $display("FAIL join_state: ptr=%b/%b cnt=%0d/%0d, required ptr=0 cnt=1", d1.ptr, d2.ptr, d1.cnt, d2.cnt);
        end
      end
      step;
    end
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

  task automatic test_interleaved;
    step;
    a_valid = 1'b1; a_we = 1'b1; b_we = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      a_addr = 10'(i);
      a_wdata = 32'(i * 17);
      step;
    end
    a_valid = 1'b0;
    step;
    a_valid = 1'b1; a_we = 1'b0; a_addr = 10'd1;
    @(negedge clk);
    checks++;
    if (a_ready[1] !== 1'b1) begin
      errors++;
      $display("FAIL il_issue_a1: a_ready=%b, required 1", a_ready[1]);
    end
    step;
    a_valid = 1'b0; b_valid = 1'b1; b_addr = 10'd2;
    @(negedge clk);
    checks++;
    if (b_ready[1] !== 1'b1) begin
      errors++;
      $display("FAIL il_issue_b2: b_ready=%b, required 1", b_ready[1]);
    end
    step;
    b_valid = 1'b0; a_valid = 1'b1; a_addr = 10'd3;
    @(negedge clk);
    checks++;
    if (a_rvalid[1] !== 1'b1 || a_rdata[1] !== 32'h11 || a_ready[1] !== 1'b1) begin
      errors++;
      $display("FAIL il_ret_a1: a_rvalid=%b a_rdata=%h a_ready=%b, required 1 00000011 1", a_rvalid[1], a_rdata[1], a_ready[1]);
    end
    step;
    a_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (b_rvalid[1] !== 1'b1 || b_rdata[1] !== 32'h22 || a_rvalid[1] !== 1'b0) begin
      errors++;
      $display("FAIL il_ret_b2: b_rvalid=%b b_rdata=%h a_rvalid=%b, required 1 00000022 0", b_rvalid[1], b_rdata[1], a_rvalid[1]);
    end
    step;
    @(negedge clk);
    checks++;
    if (a_rvalid[1] !== 1'b1 || a_rdata[1] !== 32'h33 || b_rdata[1] !== 32'h22) begin
      errors++;
      $display("FAIL il_ret_a3: a_rvalid=%b a_rdata=%h b_rdata=%h, required 1 00000033 00000022", a_rvalid[1], a_rdata[1], b_rdata[1]);
    end
  endtask

  task automatic test_reset_mid;
    step;
    a_valid = 1'b1; a_we = 1'b0; a_addr = 10'd5;
    step;
    a_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    checks++;
    if (a_rvalid[0] !== 1'b0 || a_rvalid[1] !== 1'b0 || a_ready[0] !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: a_rvalid=%b/%b a_ready=%b, required 0/0 0", a_rvalid[0], a_rvalid[1], a_ready[0]);
    end
    step;
    rst = 1'b0; a_valid = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (a_rvalid[k] !== 1'b0 || a_ready[k] !== 1'b1 || mem_en[k] !== 1'b1) begin
        errors++;
        $display("FAIL rst_resume%0d: a_rvalid=%b a_ready=%b en=%b, required 0 1 1", k, a_rvalid[k], a_ready[k], mem_en[k]);
      end
    end
    step;
    a_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (a_rvalid[0] !== 1'b1 || a_rdata[0] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL rst_resume_ret: a_rvalid=%b a_rdata=%h, required 1 deadbeef", a_rvalid[0], a_rdata[0]);
    end
  endtask

  initial begin
    test_reset;
    test_read;
    test_round_robin;
    test_burst_hold;
    test_interleaved;
    test_reset_mid;
    repeat (4) step;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (sb[k].size() != 0) begin
        errors++;
        $display("FAIL drain%0d: %0d responses outstanding, required 0", k, sb[k].size());
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
